cordic_arbiter: RTL and testbench
=================================

// Module: cordic_arbiter
// PURPOSE
//  Shares one pipelined CORDIC core (x/y/z/mode in, x/y/z out, fixed LATENCY, no stall) between NREQ requesters.
//  Valid/ready per requester, round-robin grant, ID tag pipeline to route results back.
//  The core's mode input is global, not pipelined: mode changes only with the core pipeline empty (drain-then-switch).
//  Sits between sample sources (rotation/vector clients) and the cordic instance.
// PARAMETERS
//  W        16  data width of x/y/z (two's complement)
//  NREQ     2   number of requesters (2..4)
//  LATENCY  16  cordic input-to-output latency in clk cycles (>=1)
// PORTS
//  clk        in   1        clock, all logic on posedge
//  rst_n      in   1        synchronous reset, active-low
//  req_valid  in   NREQ     request present, bit i = requester i
//  req_ready  out  NREQ     request accepted this cycle (valid&ready = transfer)
//  req_mode   in   NREQ     requested mode per requester: 0 rotation, 1 vector
//  req_x/y/z  in   NREQ*W   packed operands, requester i at [i*W +: W]
//  cor_x/y/z  out  W        to cordic x_in/y_in/z_in (registered)
//  cor_mode   out  1        to cordic mode (registered, constant while in-flight>0)
//  cor_xo/yo/zo in W        from cordic x_out/y_out/z_out
//  res_valid  out  NREQ     one-cycle result strobe for requester i (no backpressure)
//  res_x/y/z  out  W        result data, valid when any res_valid bit set
//  inflight   out  clog2(LATENCY+2)  ops issued and not yet returned
//  busy       out  1        inflight!=0 or state!=IDLE
// BEHAVIOUR
//  Reset: req_ready=0, res_valid=0, cor_x/y/z=0, cor_mode=0, inflight=0, rr pointer=0, tag pipe cleared, state IDLE.
//  Reset mid-operation: tag pipe cleared, so cordic outputs still emerging are discarded (no res_valid).
//  Arbitration (combinational): round-robin starting at rr_ptr over req_valid; candidate c. rr_ptr <= c+1 mod NREQ on grant.
//  At most one req_ready bit high per cycle; req_ready never high without req_valid.
//  States:
//   IDLE : inflight==0. Candidate exists -> grant c, cor_mode<=req_mode[c], -> RUN.
//   RUN  : candidate mode==cor_mode -> grant. Else no grant, latch tgt=c, -> DRAIN.
//          inflight reaches 0 with no candidate -> IDLE.
//   DRAIN: no grants to anyone. When inflight==0: cor_mode<=req_mode[tgt], grant tgt same cycle if still valid, -> RUN;
//          if tgt dropped valid -> IDLE.
//  Issue: on grant, cor_x/y/z<=req operands next edge; tag pipe stage0 <= {1,id}. No grant: cor_x/y/z hold, tag valid 0.
//  Tag pipe: LATENCY-deep shift register of {valid,id}, aligned with cordic; result at stage LATENCY.
//  Latency: transfer at edge T -> res_valid[id] high in cycle after edge T+1+LATENCY; data = cor_xo/yo/zo, registered.
//  Back-to-back grants: one per cycle, full throughput in same mode.
//  inflight: +1 on grant, -1 on tag exit, both same cycle -> unchanged; never exceeds LATENCY+1.
//  Requester must hold req_valid/operands stable until ready; dropping valid early is legal (request withdrawn).
//  res_x/y/z hold last value when no strobe.
// CONFIGURATION
//  CORDIC_ARB_FIXED_PRIO_EN defined: requester 0 highest, NREQ-1 lowest fixed priority; rr_ptr removed.
//   DRAIN target still latched and honoured (no preemption of a latched target).
//  Undefined (default): round-robin as above.
// STRUCTURE
//  Package cordic_arb_pkg: state enum (IDLE,RUN,DRAIN), MODE_ROT=0/MODE_VEC=1 constants, id width function.
//  Sub-module cordic_tag_pipe (LATENCY-deep {valid,id} shift register, parameter LATENCY, IDW).
//  Top holds arbiter, FSM, issue registers, inflight counter, result demux.
// TESTING (bench uses a behavioural LATENCY-deep delay model for the core, W=16, NREQ=2, LATENCY=16)
//  1 Single req: r0 x=1000,y=0,z=100, mode 0 -> ready 1 cycle, res_valid[0] 17 cycles after transfer, data matches model.
//  2 Both valid, mode 0, continuous -> grants alternate r0,r1,r0..., one per cycle, results routed to correct ids in order.
//  3 r0 mode 0 streaming, r1 raises mode 1 -> no grants until inflight==0, cor_mode flips to 1, r1 granted, then back.
//  4 Assert rst_n=0 one cycle with inflight=10 -> no res_valid from discarded ops, all outputs at reset values next cycle.
//  5 DRAIN with tgt withdrawing req_valid -> FSM to IDLE when inflight==0, cor_mode unchanged, no spurious grant.
//  6 CORDIC_ARB_FIXED_PRIO_EN, both valid, same mode -> r0 granted every cycle, r1 starved until r0 drops.

Source files
------------

// File: rtl/cordic_arb_pkg.sv
// Shared types and helpers for the CORDIC arbiter slice.
//   arb_state_e : arbiter FSM states (IDLE, RUN, DRAIN)
//   MODE_ROT/VEC: values driven on the core's global mode input
//   id_width()  : bit width of a requester id for a given requester count
package cordic_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cordic_tag_pipe.sv
// Tag pipeline that travels alongside the CORDIC core so each result can be
// routed back to the requester that issued it.
// Stage 0 is loaded on the same edge as the core's input registers; stage
// LATENCY therefore lines up with the core's output.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset (clears valids)
//   in_vld_i, in_id_i   : tag entering with an issued operation
//   out_vld_o, out_id_o : tag aligned with the core output
module cordic_tag_pipe
    import cordic_arb_pkg::*;
#(
    parameter int LATENCY = 16,
    parameter int IDW     = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_vld_i,
    input  logic [IDW-1:0] in_id_i,
    output logic           out_vld_o,
    output logic [IDW-1:0] out_id_o
);

    logic [LATENCY:0] vld_q;
    logic [IDW-1:0]   id_q [0:LATENCY];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[LATENCY-1:0], in_vld_i};
        end
    end

    // Ids carry no reset: they are only looked at when the matching valid is set.
    always_ff @(posedge clk) begin
        id_q[0] <= in_id_i;
        for (int i = 1; i <= LATENCY; i++) begin
            id_q[i] <= id_q[i-1];
        end
    end

    assign out_vld_o = vld_q[LATENCY];
    assign out_id_o  = id_q[LATENCY];

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one pipelined CORDIC core between NREQ requesters.
// Requests are arbitrated (round-robin by default), issued into registered
// core inputs, tagged with the requester id and the returning core output is
// registered and strobed to the owning requester. The core mode input is
// global, so a mode change waits until the core pipeline has drained.
// Build option: define CORDIC_ARB_FIXED_PRIO_EN for fixed priority
// (requester 0 highest) instead of round-robin.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   req_valid/ready/mode    : per-requester handshake and requested mode
//   req_x/y/z               : packed operands, requester i at [i*W +: W]
//   cor_x/y/z, cor_mode     : registered drive to the core inputs
//   cor_xo/yo/zo            : core outputs
//   res_valid, res_x/y/z    : one-cycle result strobe per requester + data
//   inflight, busy          : outstanding operations / activity status
module cordic_arbiter
    import cordic_arb_pkg::*;
#(
    parameter int W       = 16,
    parameter int NREQ    = 2,
    parameter int LATENCY = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ-1:0]               req_mode,
    input  logic [NREQ*W-1:0]             req_x,
    input  logic [NREQ*W-1:0]             req_y,
    input  logic [NREQ*W-1:0]             req_z,
    output logic signed [W-1:0]           cor_x,
    output logic signed [W-1:0]           cor_y,
    output logic signed [W-1:0]           cor_z,
    output logic                          cor_mode,
    input  logic signed [W-1:0]           cor_xo,
    input  logic signed [W-1:0]           cor_yo,
    input  logic signed [W-1:0]           cor_zo,
    output logic [NREQ-1:0]               res_valid,
    output logic signed [W-1:0]           res_x,
    output logic signed [W-1:0]           res_y,
    output logic signed [W-1:0]           res_z,
    output logic [$clog2(LATENCY+2)-1:0]  inflight,
    output logic                          busy
);

    localparam int IDW = id_width(NREQ);
    localparam int IFW = $clog2(LATENCY + 2);

    arb_state_e          state_q, state_d;
    logic                mode_q, mode_d;
    logic [IDW-1:0]      tgt_q, tgt_d;
    logic [IFW-1:0]      inflight_q, inflight_d;
    logic                cand_vld;
    logic [IDW-1:0]      cand_id;
    logic                grant;
    logic [IDW-1:0]      gnt_id;
    logic signed [W-1:0] op_x [NREQ];
    logic signed [W-1:0] op_y [NREQ];
    logic signed [W-1:0] op_z [NREQ];
    logic signed [W-1:0] cor_x_q, cor_y_q, cor_z_q;
    logic signed [W-1:0] res_x_q, res_y_q, res_z_q;
    logic [NREQ-1:0]     res_valid_q, res_valid_d;
    logic                tag_vld;
    logic [IDW-1:0]      tag_id;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            op_x[i] = req_x[i*W +: W];
            op_y[i] = req_y[i*W +: W];
            op_z[i] = req_z[i*W +: W];
        end
    end

`ifdef CORDIC_ARB_FIXED_PRIO_EN
    // Lowest index wins: scan from the top so the last hit is the smallest.
    always_comb begin
        cand_vld = 1'b0;
        cand_id  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                cand_vld = 1'b1;
                cand_id  = IDW'(k);
            end
        end
    end
`else
    logic [IDW-1:0] rr_q, rr_d;
    logic [IDW-1:0] scan_id;

    // Scan offsets from far to near so the requester closest to rr_q wins.
    always_comb begin
        cand_vld = 1'b0;
        cand_id  = '0;
        scan_id  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_id = IDW'((int'(rr_q) + k) % NREQ);
            if (req_valid[scan_id]) begin
                cand_vld = 1'b1;
                cand_id  = scan_id;
            end
        end
    end

    assign rr_d = grant ? IDW'((int'(gnt_id) + 1) % NREQ) : rr_q;
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        tgt_d   = tgt_q;
        grant   = 1'b0;
        gnt_id  = cand_id;
        case (state_q)
            IDLE: begin
                if (cand_vld) begin
                    grant   = 1'b1;
                    mode_d  = req_mode[cand_id];
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cand_vld) begin
                    if (req_mode[cand_id] == mode_q) begin
                        grant = 1'b1;
                    end else begin
                        tgt_d   = cand_id;
                        state_d = DRAIN;
                    end
                end else if (inflight_q == '0) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                // The latched target is served first even if others are waiting.
                if (inflight_q == '0) begin
                    if (req_valid[tgt_q]) begin
                        grant   = 1'b1;
                        gnt_id  = tgt_q;
                        mode_d  = req_mode[tgt_q];
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // No handshake may complete on a reset edge.
        if (!rst_n) begin
            grant = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[gnt_id] = 1'b1;
        end
        res_valid_d = '0;
        if (tag_vld) begin
            res_valid_d[tag_id] = 1'b1;
        end
    end

    assign inflight_d = inflight_q + IFW'(grant) - IFW'(tag_vld);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= MODE_ROT;
            tgt_q       <= '0;
            inflight_q  <= '0;
            res_valid_q <= '0;
`ifndef CORDIC_ARB_FIXED_PRIO_EN
            rr_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            tgt_q       <= tgt_d;
            inflight_q  <= inflight_d;
            res_valid_q <= res_valid_d;
`ifndef CORDIC_ARB_FIXED_PRIO_EN
            rr_q        <= rr_d;
`endif
        end
    end

    // Issue stage: core input registers, held when nothing is granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cor_x_q <= '0;
            cor_y_q <= '0;
            cor_z_q <= '0;
        end else if (grant) begin
            cor_x_q <= op_x[gnt_id];
            cor_y_q <= op_y[gnt_id];
            cor_z_q <= op_z[gnt_id];
        end
    end

    cordic_tag_pipe #(
        .LATENCY (LATENCY),
        .IDW     (IDW)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld_i  (grant),
        .in_id_i   (gnt_id),
        .out_vld_o (tag_vld),
        .out_id_o  (tag_id)
    );

    // Result stage: capture core output when its tag is live, else hold.
    always_ff @(posedge clk) begin
        if (tag_vld) begin
            res_x_q <= cor_xo;
            res_y_q <= cor_yo;
            res_z_q <= cor_zo;
        end
    end

    assign cor_x     = cor_x_q;
    assign cor_y     = cor_y_q;
    assign cor_z     = cor_z_q;
    assign cor_mode  = mode_q;
    assign res_valid = res_valid_q;
    assign res_x     = res_x_q;
    assign res_y     = res_y_q;
    assign res_z     = res_z_q;
    assign inflight  = inflight_q;
    assign busy      = (inflight_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter (W=16, NREQ=2, LATENCY=16).
// The core is modelled as a 16-cycle delay line applying x+1, y-1 and
// z + (mode ? 0x4000 : 0), so returned data also proves the mode in force.
module tb_cordic_arbiter;

    localparam int W    = 16;
    localparam int NREQ = 2;
    localparam int LAT  = 16;
    localparam int IFW  = $clog2(LAT + 2);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid, req_ready, req_mode;
    logic [NREQ*W-1:0] req_x, req_y, req_z;
    logic [W-1:0]      cor_x, cor_y, cor_z, cor_xo, cor_yo, cor_zo;
    logic              cor_mode;
    logic [NREQ-1:0]   res_valid;
    logic [W-1:0]      res_x, res_y, res_z;
    logic [IFW-1:0]    inflight;
    logic              busy;

    always #5 clk = ~clk;

    cordic_arbiter #(.W(W), .NREQ(NREQ), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .cor_x(cor_x), .cor_y(cor_y), .cor_z(cor_z), .cor_mode(cor_mode),
        .cor_xo(cor_xo), .cor_yo(cor_yo), .cor_zo(cor_zo),
        .res_valid(res_valid), .res_x(res_x), .res_y(res_y), .res_z(res_z),
        .inflight(inflight), .busy(busy)
    );

    // Behavioural core: LAT-deep delay of inputs and the mode seen at input.
    logic [W-1:0] dx [LAT];
    logic [W-1:0] dy [LAT];
    logic [W-1:0] dz [LAT];
    logic         dm [LAT];
    always @(posedge clk) begin
        dx[0] <= cor_x; dy[0] <= cor_y; dz[0] <= cor_z; dm[0] <= cor_mode;
        for (int i = 1; i < LAT; i++) begin
            dx[i] <= dx[i-1]; dy[i] <= dy[i-1]; dz[i] <= dz[i-1]; dm[i] <= dm[i-1];
        end
    end
    assign cor_xo = dx[LAT-1] + 16'd1;
    assign cor_yo = dy[LAT-1] - 16'd1;
    assign cor_zo = dz[LAT-1] + (dm[LAT-1] ? 16'h4000 : 16'h0000);

    typedef struct packed { logic [W-1:0] x, y, z; logic mode; } op_t;
    typedef struct packed { logic id; logic [W-1:0] x, y, z; int due; } exp_t;

    op_t  q0[$];
    op_t  q1[$];
    exp_t sb[$];
    int   gl_id[$];
    int   gl_cyc[$];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic [NREQ-1:0] hs_q = '0;
    bit   log_en = 0, t3_on = 0, t5_on = 0, last_mode_vld = 0;
    logic last_mode = 1'b0;
    int   t3_bad = 0, t5_r1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic op_t mk(input logic [W-1:0] x, y, z, input logic m);
        op_t o;
        o.x = x; o.y = y; o.z = z; o.mode = m;
        return o;
    endfunction

    // Driver: present each queue's head until it is accepted.
    initial begin
        req_valid = '0; req_mode = '0; req_x = '0; req_y = '0; req_z = '0;
        forever begin
            @(posedge clk); #1;
            if (hs_q[0] && q0.size() > 0) void'(q0.pop_front());
            if (hs_q[1] && q1.size() > 0) void'(q1.pop_front());
            hs_q = '0;
            if (q0.size() > 0) begin
                req_valid[0] = 1'b1; req_mode[0] = q0[0].mode;
                req_x[15:0] = q0[0].x; req_y[15:0] = q0[0].y; req_z[15:0] = q0[0].z;
            end else req_valid[0] = 1'b0;
            if (q1.size() > 0) begin
                req_valid[1] = 1'b1; req_mode[1] = q1[0].mode;
                req_x[31:16] = q1[0].x; req_y[31:16] = q1[0].y; req_z[31:16] = q1[0].z;
            end else req_valid[1] = 1'b0;
        end
    end

    // Issue side: on each accepted request push the expected result.
    initial begin
        forever begin
            logic [NREQ-1:0] h;
            op_t  o;
            exp_t e;
            @(negedge clk);
            h = req_valid & req_ready;
            hs_q = h;
            if (req_valid != '0) begin
                chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
                chk("ready_without_valid", 32'(req_ready & ~req_valid), 32'd0);
            end
            if (inflight != '0) chk("inflight_bound", 32'(inflight <= IFW'(LAT + 1)), 32'd1);
            if (h != '0) begin
                o = h[1] ? q1[0] : q0[0];
                if (last_mode_vld && o.mode != last_mode)
                    chk("mode_switch_needs_empty", 32'(inflight), 32'd0);
                last_mode = o.mode; last_mode_vld = 1'b1;
                e.id = h[1]; e.x = o.x + 16'd1; e.y = o.y - 16'd1;
                e.z = o.z + (o.mode ? 16'h4000 : 16'h0000);
                e.due = cyc + LAT + 2;
                sb.push_back(e);
                if (log_en) begin gl_id.push_back(h[1] ? 1 : 0); gl_cyc.push_back(cyc); end
                if (t3_on && h[0] && req_valid[1]) t3_bad++;
                if (t5_on && h[1]) t5_r1++;
            end
        end
    end

    // Monitor: compare every result strobe with the scoreboard head.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (res_valid != '0) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_result: res_valid=%b with none outstanding (cycle %0d)", res_valid, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("res_id", 32'(res_valid), e.id ? 32'd2 : 32'd1);
                    chk("res_x", 32'(res_x), 32'(e.x));
                    chk("res_y", 32'(res_y), 32'(e.y));
                    chk("res_z", 32'(res_z), 32'(e.z));
                    chk("res_latency", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    task automatic wait_drained();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0 || busy) && n < 600) begin
            @(negedge clk); #1; n++;
        end
        chk("drain_timeout", 32'(n < 600), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_cor_x"},     32'(cor_x), 32'd0);
        chk({tag, "_cor_y"},     32'(cor_y), 32'd0);
        chk({tag, "_cor_z"},     32'(cor_z), 32'd0);
        chk({tag, "_cor_mode"},  32'(cor_mode), 32'd0);
        chk({tag, "_inflight"},  32'(inflight), 32'd0);
        chk({tag, "_busy"},      32'(busy), 32'd0);
    endtask

    initial begin
        int exp_ids[8];
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;

        // Single request from r0.
        q0.push_back(mk(16'd1000, 16'd0, 16'd100, 1'b0));
        @(negedge clk); #1;
        chk("t1_ready_first_cycle", 32'(req_ready), 32'd1);
        wait_drained();
        chk("t1_res_x", 32'(res_x), 32'd1001);
        chk("t1_res_y", 32'(res_y), 32'hFFFF);
        chk("t1_res_z", 32'(res_z), 32'd100);
        chk("t1_cor_x_hold", 32'(cor_x), 32'd1000);

        // Both requesters, same mode, continuous.
        log_en = 1; gl_id.delete(); gl_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(16'h0100 + 16'(i), 16'h0010 * 16'(i), 16'h0A00 + 16'(i), 1'b0));
            q1.push_back(mk(16'h0200 + 16'(i), 16'hFF00 - 16'(i), 16'h0B00 + 16'(i), 1'b0));
        end
        wait_drained();
        log_en = 0;
`ifdef CORDIC_ARB_FIXED_PRIO_EN
        exp_ids = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        exp_ids = '{1, 0, 1, 0, 1, 0, 1, 0};
`endif
        chk("t2_grant_count", 32'(gl_id.size()), 32'd8);
        if (gl_id.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("t2_grant_order", 32'(gl_id[i]), 32'(exp_ids[i]));
                if (i > 0) chk("t2_back_to_back", 32'(gl_cyc[i] - gl_cyc[i-1]), 32'd1);
            end
        end

        // r0 streams rotation, r1 asks for vectoring mid-stream.
        t3_on = 1; t3_bad = 0;
        for (int i = 0; i < 6; i++) q0.push_back(mk(16'h1000 + 16'(i), 16'h0001, 16'h0002 + 16'(i), 1'b0));
        repeat (3) begin @(negedge clk); #1; end
        q1.push_back(mk(16'h7000, 16'h0123, 16'h0011, 1'b1));
        wait_drained();
        t3_on = 0;
`ifdef CORDIC_ARB_FIXED_PRIO_EN
        chk("t3_final_mode", 32'(cor_mode), 32'd1);
`else
        chk("t3_no_grant_while_draining", 32'(t3_bad), 32'd0);
        chk("t3_final_mode", 32'(cor_mode), 32'd0);
`endif

        // Drain target withdraws its request.
        t5_on = 1; t5_r1 = 0;
        q0.push_back(mk(16'h2000, 16'h2001, 16'h2002, 1'b0));
        q0.push_back(mk(16'h2010, 16'h2011, 16'h2012, 1'b0));
        repeat (4) begin @(negedge clk); #1; end
        q1.push_back(mk(16'h5555, 16'h6666, 16'h0777, 1'b1));
        repeat (2) begin @(negedge clk); #1; end
        chk("t5_drain_no_ready", 32'(req_ready), 32'd0);
        chk("t5_busy_draining", 32'(busy), 32'd1);
        @(negedge clk); #1;
        q1.delete();
        wait_drained();
        repeat (2) begin @(negedge clk); #1; end
        t5_on = 0;
        chk("t5_no_grant_to_withdrawn", 32'(t5_r1), 32'd0);
        chk("t5_mode_unchanged", 32'(cor_mode), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);

        // Reset with ten operations in flight.
        for (int i = 0; i < 12; i++) q0.push_back(mk(16'h3000 + 16'(i), 16'h3100, 16'h3200, 1'b0));
        n = 0;
        while (inflight != IFW'(10) && n < 40) begin @(negedge clk); #1; n++; end
        chk("t4_reach_inflight10", 32'(inflight), 32'd10);
        rst_n = 1'b0;
        q0.delete(); sb.delete(); last_mode_vld = 0;
        @(negedge clk); #1;
        check_reset_state("t4");
        rst_n = 1'b1;
        repeat (25) begin @(negedge clk); #1; end
        q1.push_back(mk(16'h0042, 16'h0043, 16'h0044, 1'b0));
        wait_drained();
        chk("t4_after_reset_x", 32'(res_x), 32'h0043);
        chk("t4_after_reset_z", 32'(res_z), 32'h0044);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
